// File: rtl/threshold_table_loader.sv
// Threshold table loader: serial divider fills the comparator result RAM.
// Optional: THR_LOADER_EARLY_SAT_EN skips the divider once entries saturate.
module threshold_table_loader #(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
    parameter int FRAC_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_Start,
    input  logic [FRAC_BITS-1:0] i_Threshold,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_TableValid,
    output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
    output logic [CNT_WIDTH:0]   o_BRAM_Din,
    output logic                 o_BRAM_En,
    output logic                 o_BRAM_WrEn
);

    localparam int NW   = CNT_WIDTH + FRAC_BITS;
    localparam int RW   = FRAC_BITS + 1;
    localparam int EW   = CNT_WIDTH + 1;
    localparam int SW   = $clog2(NW + 1);
    localparam int SUMW = NW + 1;
    localparam logic [EW-1:0]        SAT  = '1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VECTOR_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_DIV, S_WRITE, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] c_q, c_d;
    logic [RW-1:0]        dn_q, dn_d;
    logic [NW-1:0]        num_q, num_d;
    logic [RW-1:0]        rem_q, rem_d;
    logic [SW-1:0]        step_q, step_d;
    logic                 valid_q, valid_d;

    logic [RW-1:0]   dn_start;
    logic [RW:0]     trial;
    logic            ge;
    logic [RW-1:0]   rem_sub;
    logic [SUMW-1:0] sum;
    logic [EW-1:0]   bound;

    assign dn_start = (RW'(1) << FRAC_BITS) - {1'b0, i_Threshold};

    // Restoring step: bring in next numerator bit, subtract if it fits
    assign trial   = {rem_q, num_q[NW-1]};
    assign ge      = trial >= {1'b0, dn_q};
    assign rem_sub = RW'(trial - {1'b0, dn_q});

    assign sum = SUMW'(num_q) + SUMW'(rem_q != '0) + SUMW'(c_q);

`ifdef THR_LOADER_EARLY_SAT_EN
    localparam int AW = EW + RW;
    logic [AW-1:0] acc_q, acc_d;
    logic          sat_q, sat_d;
    logic [AW-1:0] acc_nx;
    logic [AW-1:0] num_nx;
    logic          sat_nx;

    // acc tracks (2^EW-1-C)*Dn; entry C saturates iff C<<F exceeds it
    assign acc_nx = acc_q - AW'(dn_q);
    assign num_nx = (AW'(c_q) + AW'(1)) << FRAC_BITS;
    assign sat_nx = num_nx > acc_nx;
    assign bound  = (sat_q || sum > SUMW'(SAT)) ? SAT : sum[EW-1:0];
`else
    assign bound  = (sum > SUMW'(SAT)) ? SAT : sum[EW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            dn_q    <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            step_q  <= '0;
            valid_q <= 1'b0;
`ifdef THR_LOADER_EARLY_SAT_EN
            acc_q   <= '0;
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            dn_q    <= dn_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            valid_q <= valid_d;
`ifdef THR_LOADER_EARLY_SAT_EN
            acc_q   <= acc_d;
            sat_q   <= sat_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        dn_d        = dn_q;
        num_d       = num_q;
        rem_d       = rem_q;
        step_d      = step_q;
        valid_d     = valid_q;
`ifdef THR_LOADER_EARLY_SAT_EN
        acc_d       = acc_q;
        sat_d       = sat_q;
`endif
        o_Busy      = 1'b0;
        o_Done      = 1'b0;
        o_BRAM_En   = 1'b0;
        o_BRAM_WrEn = 1'b0;
        o_BRAM_Addr = '0;
        o_BRAM_Din  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    dn_d    = dn_start;
                    c_d     = '0;
                    valid_d = 1'b0;
                    state_d = S_INIT;
`ifdef THR_LOADER_EARLY_SAT_EN
                    acc_d   = (AW'(dn_start) << EW) - AW'(dn_start);
                    sat_d   = 1'b0;
`endif
                end
            end
            S_INIT: begin
                o_Busy  = 1'b1;
                num_d   = NW'(c_q) << FRAC_BITS;
                rem_d   = '0;
                step_d  = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                o_Busy = 1'b1;
                num_d  = {num_q[NW-2:0], ge};
                rem_d  = ge ? rem_sub : trial[RW-1:0];
                step_d = step_q + SW'(1);
                if (step_q == SW'(NW - 1)) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                o_Busy      = 1'b1;
                o_BRAM_En   = 1'b1;
                o_BRAM_WrEn = 1'b1;
                o_BRAM_Addr = c_q;
                o_BRAM_Din  = bound;
                if (c_q == LAST) begin
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    c_d     = c_q + CNT_WIDTH'(1);
                    state_d = S_INIT;
`ifdef THR_LOADER_EARLY_SAT_EN
                    acc_d   = acc_nx;
                    if (sat_q || sat_nx) begin
                        sat_d   = 1'b1;
                        state_d = S_WRITE;
                    end
`endif
                end
            end
            S_DONE: begin
                o_Done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_TableValid = valid_q;

endmodule

// File: tb/tb_threshold_table_loader.sv
// Directed bench for threshold_table_loader.
// Honours THR_LOADER_EARLY_SAT_EN for the cycle-count expectation.
module tb_threshold_table_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_Start = 1'b0;
    logic [7:0]  i_Threshold = '0;
    logic        o_Busy, o_Done, o_TableValid;
    logic [9:0]  o_BRAM_Addr;
    logic [10:0] o_BRAM_Din;
    logic        o_BRAM_En, o_BRAM_WrEn;

    threshold_table_loader dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_Start      (i_Start),
        .i_Threshold  (i_Threshold),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_TableValid (o_TableValid),
        .o_BRAM_Addr  (o_BRAM_Addr),
        .o_BRAM_Din   (o_BRAM_Din),
        .o_BRAM_En    (o_BRAM_En),
        .o_BRAM_WrEn  (o_BRAM_WrEn)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tbl [0:920];
    int wr_cnt = 0;
    int done_cnt = 0;
    int order_bad = 0;
    int last_addr = -1;
    bit prev_wr = 1'b0;

`ifdef THR_LOADER_EARLY_SAT_EN
    localparam int CYC192 = 410 * 20 + 511 + 1;
`else
    localparam int CYC192 = 921 * 20 + 1;
`endif

    always @(negedge clk) begin
        if (o_BRAM_WrEn) begin
            if (int'(o_BRAM_Addr) != wr_cnt || prev_wr || !o_BRAM_En)
                order_bad++;
            if (int'(o_BRAM_Addr) <= 920)
                tbl[int'(o_BRAM_Addr)] = int'(o_BRAM_Din);
            wr_cnt++;
            last_addr = int'(o_BRAM_Addr);
        end else if (o_BRAM_En) begin
            order_bad++;
        end
        if (o_Done) done_cnt++;
        prev_wr = o_BRAM_WrEn;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_cnt = 0;
        done_cnt = 0;
        order_bad = 0;
        last_addr = -1;
        for (int i = 0; i <= 920; i++) tbl[i] = -1;
    endtask

    task automatic run_load(input logic [7:0] thr, input int extra,
                            output int cyc);
        clear_log();
        @(posedge clk); #1;
        i_Threshold = thr;
        i_Start = 1'b1;
        @(posedge clk); #1;
        i_Start = 1'b0;
        cyc = 1;
        check("busy_after_start", 32'(o_Busy), 1);
        check("valid_cleared", 32'(o_TableValid), 0);
        while (!o_Done && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            i_Start = (cyc == extra);
        end
        check("done_seen", 32'(o_Done), 1);
        check("valid_at_done", 32'(o_TableValid), 1);
        check("busy_at_done", 32'(o_Busy), 0);
        @(posedge clk); #1;
        i_Start = 1'b0;
    endtask

    initial begin
        int cyc;
        int w0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", 32'(o_Busy), 0);
        check("rst_done", 32'(o_Done), 0);
        check("rst_valid", 32'(o_TableValid), 0);
        check("rst_en", 32'(o_BRAM_En), 0);
        check("rst_wren", 32'(o_BRAM_WrEn), 0);
        check("rst_addr", 32'(o_BRAM_Addr), 0);
        check("rst_din", 32'(o_BRAM_Din), 0);

        run_load(8'd0, 0, cyc);
        check("t0_cycles", 32'(cyc), 18421);
        check("t0_writes", 32'(wr_cnt), 921);
        check("t0_order", 32'(order_bad), 0);
        check("t0_R0", 32'(tbl[0]), 0);
        check("t0_R5", 32'(tbl[5]), 10);
        check("t0_R920", 32'(tbl[920]), 1840);

        run_load(8'd128, 5000, cyc);
        check("t128_writes", 32'(wr_cnt), 921);
        check("t128_dones", 32'(done_cnt), 1);
        check("t128_order", 32'(order_bad), 0);
        check("t128_R3", 32'(tbl[3]), 9);
        check("t128_R682", 32'(tbl[682]), 2046);
        check("t128_R683", 32'(tbl[683]), 2047);

        run_load(8'd100, 0, cyc);
        check("t100_R0", 32'(tbl[0]), 0);
        check("t100_R1", 32'(tbl[1]), 3);
        check("t100_R7", 32'(tbl[7]), 19);
        check("t100_R920", 32'(tbl[920]), 2047);

        run_load(8'd192, CYC192, cyc);
        check("t192_cycles", 32'(cyc), 32'(CYC192));
        check("t192_R409", 32'(tbl[409]), 2045);
        check("t192_R410", 32'(tbl[410]), 2047);
        check("t192_R920", 32'(tbl[920]), 2047);
        check("t192_order", 32'(order_bad), 0);
        repeat (30) @(posedge clk);
        #1;
        check("t192_no_restart", 32'(wr_cnt), 921);
        check("t192_idle_busy", 32'(o_Busy), 0);
        check("t192_dones", 32'(done_cnt), 1);

        clear_log();
        @(posedge clk); #1;
        i_Threshold = 8'd0;
        i_Start = 1'b1;
        @(posedge clk); #1;
        i_Start = 1'b0;
        cyc = 0;
        while (wr_cnt <= 300 && cyc < 10000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid_reached_300", 32'(wr_cnt), 301);
        rstn = 1'b0;
        w0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("mid_no_writes", 32'(wr_cnt), 32'(w0));
        check("mid_last_addr", 32'(last_addr), 300);
        check("mid_valid", 32'(o_TableValid), 0);
        check("mid_busy", 32'(o_Busy), 0);
        check("mid_no_done", 32'(done_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
